// File: rtl/fitness_eval_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fitness_eval_ctrl_pkg
// Brief    : Shared parameters, chromosome field widths and FSM state
//            encoding for the fitness evaluation controller.
// Revision : 1.0 - initial release
// ============================================================================
package fitness_eval_ctrl_pkg;

  // Default phenotype geometry
  localparam int IN_DEFAULT  = 4;
  localparam int OUT_DEFAULT = 2;

  // Chromosome field widths
  localparam int BITS_MAT  = 16;
  localparam int BITS_ELEM = 4;
  localparam int BITS_MUX  = 2;

  localparam int CHROM_W_DEFAULT = BITS_MAT + BITS_ELEM * OUT_DEFAULT + BITS_MUX;

  // Fitness width: must hold the value OUT*2^IN inclusive
  function automatic int fit_w(input int in_w, input int out_w);
    return $clog2(out_w * (1 << in_w) + 1);
  endfunction

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fitness_eval_ctrl_match_popcount.sv
`default_nettype none
// ============================================================================
// Module   : match_popcount
// Brief    : Counts how many bits of a phenotype response row agree with the
//            target row (popcount of the XNOR). Purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module match_popcount #(
  parameter  int OUT = 2,
  localparam int CW  = $clog2(OUT + 1)
) (
  input  logic [OUT-1:0] resp,
  input  logic [OUT-1:0] target,
  output logic [CW-1:0]  count
);

  logic [OUT-1:0] eq;

  assign eq = ~(resp ^ target);

  // Sum the agreeing bit positions
  always_comb begin
    count = '0;
    for (int i = 0; i < OUT; i++) begin
      count = count + CW'(eq[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fitness_eval_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fitness_eval_ctrl
// Brief    : Sweeps every input vector of an external phenotype, compares each
//            response row against a target truth table and reports the number
//            of matching output bits as the chromosome's fitness.
// Revision : 1.0 - initial release
// ============================================================================
module fitness_eval_ctrl
  import fitness_eval_ctrl_pkg::*;
#(
  parameter  int IN      = IN_DEFAULT,
  parameter  int OUT     = OUT_DEFAULT,
  parameter  int CHROM_W = BITS_MAT + BITS_ELEM * OUT + BITS_MUX,
  localparam int FIT_W   = fit_w(IN, OUT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [CHROM_W-1:0]      chrom_in,
  input  logic [OUT*(1<<IN)-1:0]  alvo_in,
  output logic [CHROM_W-1:0]      phen_chrom,
  output logic [IN-1:0]           phen_inp,
  input  logic [OUT-1:0]          phen_out,
  output logic                    busy,
  output logic                    done,
  output logic [FIT_W-1:0]        fitness,
  output logic                    perfect
);

  localparam int              ROWS    = 1 << IN;
  localparam int              MW      = $clog2(OUT + 1);
  localparam logic [IN-1:0]   V_LAST  = {IN{1'b1}};
  localparam logic [FIT_W-1:0] FIT_MAX = FIT_W'(OUT * ROWS);

  state_t                 state;
  logic [OUT*ROWS-1:0]    alvo;
  logic [IN-1:0]          v;
  logic [FIT_W-1:0]       acc;
  logic [OUT-1:0]         target;
  logic [MW-1:0]          match;
  logic [FIT_W-1:0]       sum;

  // Target row for the vector currently presented to the phenotype
  assign target = alvo[v*OUT +: OUT];

  match_popcount #(
    .OUT (OUT)
  ) u_match (
    .resp   (phen_out),
    .target (target),
    .count  (match)
  );

  assign sum = acc + FIT_W'(match);

  // Only drive the sweep index while evaluating so the phenotype sees 0 at rest
  assign phen_inp = (state == EVAL) ? v : '0;

  // Evaluation FSM: load on start, accumulate one row per cycle, publish result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      fitness    <= '0;
      perfect    <= 1'b0;
      phen_chrom <= '0;
      alvo       <= '0;
      v          <= '0;
      acc        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            phen_chrom <= chrom_in;
            alvo       <= alvo_in;
            v          <= '0;
            acc        <= '0;
            busy       <= 1'b1;
            state      <= EVAL;
          end
        end
        EVAL: begin
          if (abort) begin
            // Drop the partial result; previously published fitness stays
            busy  <= 1'b0;
            state <= IDLE;
          end else if (v == V_LAST) begin
            fitness <= sum;
            perfect <= (sum == FIT_MAX);
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            acc <= sum;
            v   <= v + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fitness_eval_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fitness_eval_ctrl
// Brief    : Directed self-checking bench for fitness_eval_ctrl, using a
//            behavioural phenotype whose function is selected by 'mode'.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fitness_eval_ctrl;
  import fitness_eval_ctrl_pkg::*;

  localparam int IN1 = 2;
  localparam int OUT1 = 1;
  localparam int CW1 = BITS_MAT + BITS_ELEM * OUT1 + BITS_MUX;
  localparam int FW1 = fit_w(IN1, OUT1);
  localparam int IN2 = 3;
  localparam int OUT2 = 2;
  localparam int CW2 = BITS_MAT + BITS_ELEM * OUT2 + BITS_MUX;
  localparam int FW2 = fit_w(IN2, OUT2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start1, abort1, start2, abort2;
  logic [CW1-1:0] chrom1, phen_chrom1;
  logic [OUT1*(1<<IN1)-1:0] alvo1;
  logic [IN1-1:0] phen_inp1;
  logic [OUT1-1:0] phen_out1;
  logic busy1, done1, perfect1;
  logic [FW1-1:0] fitness1;

  logic [CW2-1:0] chrom2, phen_chrom2;
  logic [OUT2*(1<<IN2)-1:0] alvo2;
  logic [IN2-1:0] phen_inp2;
  logic [OUT2-1:0] phen_out2;
  logic busy2, done2, perfect2;
  logic [FW2-1:0] fitness2;

  // 0: XOR of inputs, 1: constant 0, 2: all ones
  int mode;
  int checks = 0;
  int errors = 0;

  // Behavioural phenotype models
  always_comb begin
    phen_out1 = '0;
    phen_out2 = '0;
    case (mode)
      0: phen_out1 = phen_inp1[0] ^ phen_inp1[1];
      1: phen_out1 = 1'b0;
      default: begin
        phen_out1 = '1;
        phen_out2 = '1;
      end
    endcase
  end

  fitness_eval_ctrl #(.IN(IN1), .OUT(OUT1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .chrom_in(chrom1), .alvo_in(alvo1), .phen_chrom(phen_chrom1),
    .phen_inp(phen_inp1), .phen_out(phen_out1), .busy(busy1),
    .done(done1), .fitness(fitness1), .perfect(perfect1)
  );

  fitness_eval_ctrl #(.IN(IN2), .OUT(OUT2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2),
    .chrom_in(chrom2), .alvo_in(alvo2), .phen_chrom(phen_chrom2),
    .phen_inp(phen_inp2), .phen_out(phen_out2), .busy(busy2),
    .done(done2), .fitness(fitness2), .perfect(perfect2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start1 = 0; abort1 = 0; start2 = 0; abort2 = 0;
    chrom1 = '0; alvo1 = '0; chrom2 = '0; alvo2 = '0; mode = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done1); end
    checks++; if (fitness1 !== '0) begin errors++; $display("FAIL reset_fitness: got %0d expected 0", fitness1); end
    checks++; if (perfect1 !== 1'b0) begin errors++; $display("FAIL reset_perfect: got %b expected 0", perfect1); end
    checks++; if (phen_inp1 !== '0) begin errors++; $display("FAIL reset_phen_inp: got %0d expected 0", phen_inp1); end
    checks++; if (phen_chrom1 !== '0) begin errors++; $display("FAIL reset_phen_chrom: got %h expected 0", phen_chrom1); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_xor_perfect;
    mode = 0; alvo1 = 4'b0110; chrom1 = 22'h2A5A5;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL xor_busy c%0d: got %b expected 1", c, busy1); end
      checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL xor_done_early c%0d: got %b expected 0", c, done1); end
      tick();
    end
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL xor_done: got %b expected 1", done1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL xor_busy_done: got %b expected 0", busy1); end
    checks++; if (fitness1 !== 3'd4) begin errors++; $display("FAIL xor_fitness: got %0d expected 4", fitness1); end
    checks++; if (perfect1 !== 1'b1) begin errors++; $display("FAIL xor_perfect: got %b expected 1", perfect1); end
    checks++; if (phen_chrom1 !== 22'h2A5A5) begin errors++; $display("FAIL xor_phen_chrom: got %h expected 2a5a5", phen_chrom1); end
    tick();
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL xor_done_pulse: got %b expected 0", done1); end
    checks++; if (fitness1 !== 3'd4) begin errors++; $display("FAIL xor_fitness_hold: got %0d expected 4", fitness1); end
  endtask

  task automatic test_const_zero;
    mode = 1; alvo1 = 4'b0110;
    checks++; if (phen_inp1 !== '0) begin errors++; $display("FAIL idle_phen_inp: got %0d expected 0", phen_inp1); end
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++; if (phen_inp1 !== 2'(c)) begin errors++; $display("FAIL zero_phen_inp step%0d: got %0d expected %0d", c, phen_inp1, c); end
      tick();
    end
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1", done1); end
    checks++; if (fitness1 !== 3'd2) begin errors++; $display("FAIL zero_fitness: got %0d expected 2", fitness1); end
    checks++; if (perfect1 !== 1'b0) begin errors++; $display("FAIL zero_perfect: got %b expected 0", perfect1); end
    tick();
  endtask

  task automatic test_abort;
    mode = 0; alvo1 = 4'b0110;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (4) tick();
    checks++; if (done1 !== 1'b1 || fitness1 !== 3'd4) begin errors++; $display("FAIL abort_pre_run: got done=%b fit=%0d expected done=1 fit=4", done1, fitness1); end
    tick();
    mode = 1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy1); end
    checks++; if (phen_inp1 !== '0) begin errors++; $display("FAIL abort_phen_inp: got %0d expected 0", phen_inp1); end
    for (int c = 0; c < 6; c++) begin
      checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL abort_no_done c%0d: got %b expected 0", c, done1); end
      checks++; if (fitness1 !== 3'd4 || perfect1 !== 1'b1) begin errors++; $display("FAIL abort_hold c%0d: got fit=%0d perf=%b expected fit=4 perf=1", c, fitness1, perfect1); end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    int nd;
    logic eb, ed;
    nd = 0;
    mode = 0; alvo1 = 4'b0110;
    for (int c = 0; c < 14; c++) begin
      start1 = (c < 12);
      eb = (c >= 1 && c <= 4) || (c >= 7 && c <= 10);
      ed = (c == 5) || (c == 11);
      checks++; if (busy1 !== eb) begin errors++; $display("FAIL b2b_busy c%0d: got %b expected %b", c, busy1, eb); end
      checks++; if (done1 !== ed) begin errors++; $display("FAIL b2b_done c%0d: got %b expected %b", c, done1, ed); end
      if (done1 === 1'b1) nd++;
      tick();
    end
    start1 = 1'b0;
    checks++; if (nd !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", nd); end
  endtask

  task automatic test_reset_mid_eval;
    mode = 0; alvo1 = 4'b0110; chrom1 = 22'h15555;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl: got busy=%b done=%b expected 0 0", busy1, done1); end
    checks++; if (fitness1 !== '0 || perfect1 !== 1'b0) begin errors++; $display("FAIL rstmid_result: got fit=%0d perf=%b expected 0 0", fitness1, perfect1); end
    checks++; if (phen_inp1 !== '0 || phen_chrom1 !== '0) begin errors++; $display("FAIL rstmid_phen: got inp=%0d chrom=%h expected 0 0", phen_inp1, phen_chrom1); end
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    mode = 1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (4) tick();
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL rstmid_redo_done: got %b expected 1", done1); end
    checks++; if (fitness1 !== 3'd2 || perfect1 !== 1'b0) begin errors++; $display("FAIL rstmid_redo_result: got fit=%0d perf=%b expected 2 0", fitness1, perfect1); end
    checks++; if (phen_chrom1 !== 22'h15555) begin errors++; $display("FAIL rstmid_redo_chrom: got %h expected 15555", phen_chrom1); end
    tick();
  endtask

  task automatic test_in3_out2;
    mode = 2; alvo2 = '1; chrom2 = 26'h3ABCDEF;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL w_busy c%0d: got %b expected 1", c, busy2); end
      tick();
    end
    checks++; if (done2 !== 1'b1) begin errors++; $display("FAIL w_done: got %b expected 1", done2); end
    checks++; if (fitness2 !== 5'd16) begin errors++; $display("FAIL w_fitness: got %0d expected 16", fitness2); end
    checks++; if (perfect2 !== 1'b1) begin errors++; $display("FAIL w_perfect: got %b expected 1", perfect2); end
    tick();
  endtask

  initial begin
    test_reset();
    test_xor_perfect();
    test_const_zero();
    test_abort();
    test_back_to_back();
    test_reset_mid_eval();
    test_in3_out2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
